instr_fetch_unit: RTL and testbench

Decoupled instruction-fetch stage sitting directly upstream of the processor datapath's decode/execute logic. Owns the fetch PC, issues one outstanding request at a time to a variable-latency instruction memory, buffers returned words with their PCs in a small FIFO, and hands them downstream over a valid/ready handshake. A redirect input (taken branch/jump from the datapath) flushes buffered and in-flight fetches and restarts at the new PC.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage: request FSM state
//   encodings and instruction-word geometry constants.
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  // Request FSM states (2-bit encoding).
  //   ST_IDLE : free to issue a request at fetch_pc
  //   ST_WAIT : one request outstanding, its response will be buffered
  //   ST_DROP : one request outstanding, its response will be discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_t;

  // Every instruction is one 32-bit word; fetch addresses are word aligned.
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ALIGN_BITS  = 2;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_fetch_fifo
//   Small synchronous FIFO holding fetched {pc, instruction} pairs. The head
//   entry is presented from registered storage, so a word pushed in cycle N
//   is visible at the head in cycle N+1. A flush empties the FIFO on the
//   next clock edge and overrides any push/pop issued in the same cycle.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous reset, active low
//   flush      : discard all entries
//   push       : write push_data (caller guarantees a free slot)
//   push_data  : entry to write
//   pop        : consume the head entry (ignored while empty)
//   head_valid : FIFO is non-empty
//   head_data  : head entry, zero while empty
//   count      : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module instr_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;
  logic             full;

  assign full       = (count == CNT_W'(DEPTH));
  assign head_valid = (count != '0);
  assign push_en    = push && !flush && !full;
  assign pop_en     = pop && head_valid && !flush;

  // Head reads as zero while empty so the outputs are defined right after
  // reset even though the storage array itself is not reset.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked entirely by
  // count, which keeps the array mappable onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule : instr_fetch_unit_fetch_fifo

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Decoupled instruction-fetch stage. Owns the fetch PC, keeps at most one
//   request outstanding to a variable-latency instruction memory, buffers
//   returned words with their PCs in a small FIFO and hands them downstream
//   over a valid/ready handshake. A redirect flushes the buffer, discards
//   any in-flight response and restarts fetch at the new (word-aligned) PC.
//
// Ports
//   clk              : rising-edge clock
//   rst              : synchronous reset, active low
//   imem_req_valid   : request to instruction memory
//   imem_req_ready   : memory accepts the request this cycle
//   imem_req_addr    : word-aligned byte address of the request
//   imem_resp_valid  : response word present this cycle
//   imem_resp_data   : returned instruction word
//   instr_valid      : buffered instruction available
//   instr_ready      : downstream consumes the head this cycle
//   instr_data       : head instruction
//   instr_pc         : address of the head instruction
//   redirect_valid   : restart fetch (taken branch/jump)
//   redirect_pc      : new fetch address, bits [1:0] ignored
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr_data,
  output logic [WORD_SIZE-1:0] instr_pc,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t         state;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] redirect_target;
  logic [WORD_SIZE-1:0] enq_pc;
  logic [CNT_W-1:0]     fifo_count;
  logic                 can_issue;
  logic                 req_fire;
  logic                 enq;
  logic                 deq;
  logic                 redirect_lsb_unused;

  // Low address bits of a redirect are dropped by design.
  assign redirect_lsb_unused = ^redirect_pc[ALIGN_BITS-1:0];
  assign redirect_target     = {redirect_pc[WORD_SIZE-1:ALIGN_BITS], ALIGN_BITS'(0)};

  // Only IDLE issues, so no request is outstanding when this guard is
  // evaluated; any response that follows is guaranteed a free FIFO slot.
  assign can_issue = (fifo_count < CNT_W'(DEPTH));

  // Request is held (address stable) until accepted; it drops without a
  // handshake only while in reset or during a redirect.
  assign imem_req_valid = rst && (state == ST_IDLE) && can_issue && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // fetch_pc has already advanced past the outstanding request.
  assign enq_pc = fetch_pc - WORD_SIZE'(INSTR_BYTES);
  assign enq    = (state == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign deq    = instr_valid && instr_ready;

  // Request FSM and fetch PC. Redirect has priority over normal progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      // A request still in flight must have its response swallowed later.
      if ((state != ST_IDLE) && !imem_resp_valid) state <= ST_DROP;
      else                                         state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_fire) begin
            state    <= ST_WAIT;
            fetch_pc <= fetch_pc + WORD_SIZE'(INSTR_BYTES);
          end
        end
        ST_WAIT: if (imem_resp_valid) state <= ST_IDLE;
        ST_DROP: if (imem_resp_valid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  instr_fetch_unit_fetch_fifo #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (enq),
    .push_data  ({enq_pc, imem_resp_data}),
    .pop        (deq),
    .head_valid (instr_valid),
    .head_data  ({instr_pc, instr_data}),
    .count      (fifo_count)
  );

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit: a per-cycle vector table for
//   the streaming case plus directed sequences for back-pressure, redirect,
//   stalled memory, PC wrap and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  // Auto memory responder: 1-cycle latency, returns the address as data.
  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;

  logic [31:0] hs_q[$];   // accepted request addresses
  logic [63:0] del_q[$];  // delivered {pc, data}

  typedef struct {
    logic        irdy;
    logic        exp_req_v;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  instr_fetch_unit #(
    .WORD_SIZE (32),
    .DEPTH     (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are set at the falling edge; settle drives the auto responder
  // and lets combinational outputs resolve before sampling.
  task automatic settle();
    if (mem_auto) begin
      imem_resp_valid = pend;
      imem_resp_data  = pend ? pend_addr : 32'h0;
      pend            = 1'b0;
    end
    #1;
  endtask

  task automatic advance();
    if (imem_req_valid && imem_req_ready) begin
      hs_q.push_back(imem_req_addr);
      if (mem_auto) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
      end
    end
    if (instr_valid && instr_ready) del_q.push_back({instr_pc, instr_data});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    mem_auto        = 1'b0;
    pend            = 1'b0;
    pend_addr       = 32'h0;
    hs_q.delete();
    del_q.delete();
    cycle();
    settle();
    check("rst req_valid", imem_req_valid, 0);
    check("rst req_addr",  imem_req_addr,  32'h0);
    check("rst instr_valid", instr_valid, 0);
    check("rst instr_data", instr_data,   32'h0);
    check("rst instr_pc",   instr_pc,     32'h0);
    advance();
    rst = 1'b1;
  endtask

  initial begin
    // Streaming: 1-cycle memory, addr-as-data, downstream always ready.
    vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'h4};
    vecs[5] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h8};

    // ---- table-driven streaming ----
    do_reset();
    mem_auto       = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      instr_ready = vecs[i].irdy;
      settle();
      check($sformatf("stream c%0d req_valid", i), imem_req_valid, vecs[i].exp_req_v);
      check($sformatf("stream c%0d req_addr",  i), imem_req_addr,  vecs[i].exp_addr);
      check($sformatf("stream c%0d instr_valid", i), instr_valid, vecs[i].exp_iv);
      check($sformatf("stream c%0d instr_pc",  i), instr_pc,   vecs[i].exp_pc);
      check($sformatf("stream c%0d instr_data", i), instr_data, vecs[i].exp_data);
      advance();
    end

    // ---- back-pressure: FIFO fills, issue stops, then drains ----
    do_reset();
    mem_auto       = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (30) cycle();
    settle();
    check("full req_count", hs_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (hs_q.size() > i) check($sformatf("full req%0d addr", i), hs_q[i], 32'(4 * i));
    check("full req_valid", imem_req_valid, 0);
    check("full head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (20) cycle();
    if (del_q.size() < 5) check("drain delivered", del_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (del_q.size() > i)
        check($sformatf("drain del%0d", i), del_q[i], {32'(4 * i), 32'(4 * i)});
    if (hs_q.size() > 4) check("resume addr", hs_q[4], 32'h10);
    else                 check("resume req_count", hs_q.size(), 5);

    // ---- redirect in WAIT, response next cycle; then redirect in DROP ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    settle();
    check("rdw c0 req_valid", imem_req_valid, 1);
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    settle();
    check("rdw c1 req_valid", imem_req_valid, 0);
    advance();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    settle();
    check("rdw c2 req_valid", imem_req_valid, 0);
    advance();
    imem_resp_valid = 1'b0;
    settle();
    check("rdw c3 req_valid", imem_req_valid, 1);
    check("rdw c3 req_addr",  imem_req_addr,  32'h100);
    check("rdw c3 instr_valid", instr_valid, 0);
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cycle();
    settle();
    check("rdd c5 req_valid", imem_req_valid, 0);
    advance();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h12345678;
    settle();
    check("rdd c6 req_valid", imem_req_valid, 0);
    advance();
    imem_resp_valid = 1'b0;
    settle();
    check("rdd c7 req_valid", imem_req_valid, 1);
    check("rdd c7 req_addr",  imem_req_addr,  32'h300);
    check("rdd c7 instr_valid", instr_valid, 0);

    // ---- redirect with simultaneous response, FIFO non-empty ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    cycle();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h11;
    cycle();
    imem_resp_valid = 1'b0;
    settle();
    check("rsr c2 instr_valid", instr_valid, 1);
    check("rsr c2 instr_data",  instr_data,  32'h11);
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h22;
    instr_ready = 1'b1;
    settle();
    check("rsr c3 instr_pc", instr_pc, 32'h0);
    advance();
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    settle();
    check("rsr c4 instr_valid", instr_valid, 0);
    check("rsr c4 req_valid",   imem_req_valid, 1);
    check("rsr c4 req_addr",    imem_req_addr,  32'h200);
    advance();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h33;
    cycle();
    imem_resp_valid = 1'b0;
    settle();
    check("rsr c6 instr_pc",   instr_pc,   32'h200);
    check("rsr c6 instr_data", instr_data, 32'h33);
    advance();

    // ---- memory not ready for 3 cycles: request held stable ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      imem_resp_valid = 1'b1; imem_resp_data = 32'(4 * i);
      cycle();
      imem_resp_valid = 1'b0;
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("stall s%0d req_valid", i), imem_req_valid, 1);
      check($sformatf("stall s%0d req_addr",  i), imem_req_addr,  32'h8);
      advance();
    end
    imem_req_ready = 1'b1;
    settle();
    check("stall accept addr", imem_req_addr, 32'h8);
    advance();
    settle();
    check("stall wait req_valid", imem_req_valid, 0);
    advance();

    // ---- PC wrap at 0xFFFFFFFC (redirect low bits ignored) ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    settle();
    check("wrap redirect req_valid", imem_req_valid, 0);
    advance();
    redirect_valid = 1'b0;
    settle();
    check("wrap req_addr", imem_req_addr, 32'hFFFFFFFC);
    advance();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000ABCD;
    settle();
    check("wrap fetch_pc", imem_req_addr, 32'h0);
    advance();
    imem_resp_valid = 1'b0;
    settle();
    check("wrap next req_valid", imem_req_valid, 1);
    check("wrap next req_addr",  imem_req_addr,  32'h0);
    check("wrap instr_pc",   instr_pc,   32'hFFFFFFFC);
    check("wrap instr_data", instr_data, 32'h0000ABCD);
    advance();

    // ---- reset while in WAIT, late response afterwards ignored ----
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    cycle();
    rst = 1'b0;
    settle();
    check("mrst req_valid", imem_req_valid, 0);
    advance();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h99;
    settle();
    check("mrst late req_valid", imem_req_valid, 1);
    check("mrst late req_addr",  imem_req_addr,  32'h0);
    advance();
    imem_resp_valid = 1'b0;
    settle();
    check("mrst after instr_valid", instr_valid, 0);
    check("mrst after req_addr",    imem_req_addr, 32'h0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_unit
